// File: rtl/stream_capture_pkg.sv
// Shared widths and the recorded-entry layout for the stream capture recorder.
package stream_capture_pkg;

  localparam int unsigned CAP_DATA_W = 32;
  localparam int unsigned CAP_DEPTH  = 16;
  localparam int unsigned CAP_TS_W   = 32;
  localparam int unsigned CAP_OVF_W  = 16;

  // Number of distinct timestamp values before the counter returns to 0
  localparam longint unsigned CAPTURE_TS_WRAP = 64'd1 << CAP_TS_W;

  typedef struct packed {
    logic                  drop;
    logic [CAP_TS_W-1:0]   ts;
    logic [CAP_DATA_W-1:0] data;
  } capture_entry_t;

endpackage

// File: rtl/capture_fifo.sv
// Generic synchronous first-word-fall-through FIFO with a registered head
// and a separate occupancy counter.
module capture_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_wdata,
  output logic                   o_rd_valid,
  output logic [W-1:0]           o_rd_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_rd_valid;
  logic [W-1:0]  r_rd_data;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [LW-1:0] w_level_nxt;
  logic [W-1:0]  w_head_nxt;

  assign o_full_c = (r_level == LW'(DEPTH));
  assign w_pop    = i_pop & (r_level != '0) & ~i_clear;
  assign w_push   = i_push & (~o_full_c | w_pop) & ~i_clear;

  assign w_rd_ptr_nxt = r_rd_ptr + AW'(w_pop);
  assign w_level_nxt  = r_level + LW'(w_push) - LW'(w_pop);

  // Next head: the slot being written this cycle is not yet visible in r_mem
  always_comb begin
    w_head_nxt = '0;
    if (w_level_nxt != '0) begin
      if (w_push && (w_rd_ptr_nxt == r_wr_ptr)) begin
        w_head_nxt = i_wdata;
      end else begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else if (i_clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + AW'(w_push);
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_level    <= w_level_nxt;
      r_rd_valid <= (w_level_nxt != '0);
      r_rd_data  <= w_head_nxt;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_level    = r_level;

endmodule

// File: rtl/stream_capture.sv
// Passive valid/ready tap: timestamps each handshake and queues it in an FWFT
// FIFO, tracking handshakes lost to a full FIFO.
module stream_capture
  import stream_capture_pkg::*;
#(
  parameter int unsigned DATA_W = CAP_DATA_W,
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned TS_W   = CAP_TS_W,
  parameter int unsigned OVF_W  = CAP_OVF_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   tap_valid,
  input  logic                   tap_ready,
  input  logic [DATA_W-1:0]      tap_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic [TS_W-1:0]        rd_ts,
  output logic                   rd_drop,
  output logic [$clog2(DEPTH):0] level,
  output logic [OVF_W-1:0]       overflow_cnt
);

  localparam int unsigned ENTRY_W = 1 + TS_W + DATA_W;

  typedef struct packed {
    logic              drop;
    logic [TS_W-1:0]   ts;
    logic [DATA_W-1:0] data;
  } entry_t;

  logic [TS_W-1:0]  r_ts;
  logic             r_drop_flag;
  logic [OVF_W-1:0] r_ovf_cnt;

  logic             w_cap;
  logic             w_pop;
  logic             w_full;
  logic             w_push;
  logic             w_drop;
  logic             w_fifo_valid;
  entry_t           w_wentry;
  entry_t           w_head;
  logic [ENTRY_W-1:0] w_rd_entry;

  // clear wins over a same-cycle capture, which is then neither stored nor dropped
  assign w_cap  = en & tap_valid & tap_ready & ~clear;
  assign w_pop  = w_fifo_valid & rd_ready & ~clear;
  assign w_push = w_cap & (~w_full | w_pop);
  assign w_drop = w_cap & w_full & ~w_pop;

  assign w_wentry.drop = r_drop_flag;
  assign w_wentry.ts   = r_ts;
  assign w_wentry.data = tap_data;

  capture_fifo #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clear    (clear),
    .i_push     (w_push),
    .i_pop      (rd_ready),
    .i_wdata    (w_wentry),
    .o_rd_valid (w_fifo_valid),
    .o_rd_data  (w_rd_entry),
    .o_level    (level),
    .o_full_c   (w_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // Drop flag is sticky until a push carries it; the counter saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_flag <= 1'b0;
      r_ovf_cnt   <= '0;
    end else if (clear) begin
      r_drop_flag <= 1'b0;
      r_ovf_cnt   <= '0;
    end else begin
      if (w_push) begin
        r_drop_flag <= 1'b0;
      end else if (w_drop) begin
        r_drop_flag <= 1'b1;
      end
      if (w_drop && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + OVF_W'(1);
      end
    end
  end

  assign w_head       = w_rd_entry;
  assign rd_valid     = w_fifo_valid;
  assign rd_data      = w_head.data;
  assign rd_ts        = w_head.ts;
  assign rd_drop      = w_head.drop;
  assign overflow_cnt = r_ovf_cnt;

endmodule
